// File: rtl/csa_pkg.sv
// Shared types and elaboration helpers for the carry-save streaming accumulator.
package csa_pkg;

  typedef enum logic [1:0] {
    StAcc,
    StResolve,
    StOut
  } state_e;

  function automatic int unsigned nchunk(input int unsigned w, input int unsigned chunk);
    return w / chunk;
  endfunction

  // Chunk index needs at least one bit even when the whole word resolves in one cycle.
  function automatic int unsigned idx_width(input int unsigned nch);
    return (nch <= 1) ? 1 : $clog2(nch);
  endfunction

endpackage

// File: rtl/csa_accum_if.sv
// Operand stream in, resolved result out; the accumulator is the slave side.
interface csa_accum_if #(
  parameter int unsigned W     = 186,
  parameter int unsigned CNT_W = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             in_sub;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, in_data, in_sub, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );

  modport slave (
    input  in_valid, in_data, in_sub, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count
  );

endinterface

// File: rtl/csa_stage.sv
// Combinational 3:2 compressor; the shifted carry's free bit 0 is taken from cin_i.
module csa_stage #(
  parameter int unsigned W = 186
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  input  logic [W-1:0] z_i,
  input  logic         cin_i,
  output logic [W-1:0] s_o,
  output logic [W-1:0] c_o
);

  logic [W-2:0] maj;

  // The majority MSB would shift out of the word, so it is never formed.
  assign maj = (x_i[W-2:0] & y_i[W-2:0]) | (x_i[W-2:0] & z_i[W-2:0]) |
               (y_i[W-2:0] & z_i[W-2:0]);
  assign s_o = x_i ^ y_i ^ z_i;
  assign c_o = {maj, cin_i};

endmodule

// File: rtl/csa_accum.sv
// Streaming multi-operand accumulator: carry-save accumulate, then chunked carry-propagate.
module csa_accum
  import csa_pkg::*;
#(
  parameter int unsigned W     = 186,
  parameter int unsigned CHUNK = 62,
  parameter int unsigned CNT_W = 16
) (
  input logic        clk,
  input logic        rst,
  csa_accum_if.slave bus
);

  localparam int unsigned NCH  = nchunk(W, CHUNK);
  localparam int unsigned IdxW = idx_width(NCH);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NCH - 1);

  if (W % CHUNK != 0) begin : g_bad_chunk
    $error("csa_accum: W must be a multiple of CHUNK");
  end

  state_e           state_q, state_d;
  logic [W-1:0]     sum_q, sum_d;
  logic [W-1:0]     carry_q, carry_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             cy_q, cy_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;

  logic             accept;
  logic [W-1:0]     z;
  logic [W-1:0]     csa_s, csa_c;
  logic [CHUNK-1:0] sum_chunk, carry_chunk;
  logic [CHUNK:0]   chunk_res;

  assign accept = bus.in_valid && (state_q == StAcc);
  assign z      = bus.in_sub ? ~bus.in_data : bus.in_data;

  // Subtraction is ~x + 1; the +1 rides in the carry word's empty bit 0.
  csa_stage #(
    .W(W)
  ) u_stage (
    .x_i  (sum_q),
    .y_i  (carry_q),
    .z_i  (z),
    .cin_i(bus.in_sub),
    .s_o  (csa_s),
    .c_o  (csa_c)
  );

  assign sum_chunk   = sum_q[idx_q*CHUNK +: CHUNK];
  assign carry_chunk = carry_q[idx_q*CHUNK +: CHUNK];
  assign chunk_res   = {1'b0, sum_chunk} + {1'b0, carry_chunk} + {{CHUNK{1'b0}}, cy_q};

  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    count_d     = count_q;
    cy_d        = cy_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;

    case (state_q)
      StAcc: begin
        if (accept) begin
          sum_d   = csa_s;
          carry_d = csa_c;
          count_d = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + 1'b1;
          if (bus.in_last) begin
            state_d = StResolve;
            idx_d   = '0;
            cy_d    = 1'b0;
          end
        end
      end

      StResolve: begin
        out_data_d[idx_q*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
        cy_d = chunk_res[CHUNK];
        if (idx_q == LastIdx) begin
          state_d     = StOut;
          idx_d       = '0;
          out_count_d = count_q;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      StOut: begin
        // The result settles for one cycle in OUT before it is offered.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          sum_d       = '0;
          carry_d     = '0;
          count_d     = '0;
          state_d     = StAcc;
        end
      end

      default: state_d = StAcc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StAcc;
      sum_q       <= '0;
      carry_q     <= '0;
      count_q     <= '0;
      cy_q        <= 1'b0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      count_q     <= count_d;
      cy_q        <= cy_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

  assign bus.in_ready  = (state_q == StAcc);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;

endmodule
